encode32_scan: RTL and testbench

ENCODE32_SCAN -- requirements
Module: encode32_scan

---
 rtl/encode32_scan.sv | 135 +++++++++++++
 tb/tb_encode32_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/encode32_scan.sv
// Pending-bit scanner: accepts a 32-bit vector and streams out the index of every
// set bit, one per handshake, lowest-first or highest-first.
module encode32_scan #(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_vec,
   output logic        idx_valid,
   input  logic        idx_ready,
   output logic [4:0]  idx,
   output logic        idx_last,
   output logic        empty_pulse,
   output logic [5:0]  remaining
);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pending_q, pending_d;
   logic [5:0]  remaining_q, remaining_d;
   logic        empty_q, empty_d;

   logic [4:0]  sel_idx;
   logic [31:0] sel_onehot;
   logic        in_serve;
   logic        is_last;
   logic        load_acc;
   logic        xfer;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + 6'(v[i]);
      end
      return cnt;
   endfunction

   // Scans from the top so the last hit written is the lowest set bit.
   function automatic logic [4:0] find_low(input logic [31:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) r = 5'(i);
      end
      return r;
   endfunction

   function automatic logic [4:0] find_high(input logic [31:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) r = 5'(i);
      end
      return r;
   endfunction

   // Selection comes only from registered pending bits, never from load_vec.
   always_comb begin
      sel_idx    = LOW_FIRST ? find_low(pending_q) : find_high(pending_q);
      sel_onehot = 32'd1 << sel_idx;
   end

   always_comb begin
      in_serve = (state_q == SERVE);
      is_last  = in_serve && (remaining_q == 6'd1);
      load_acc = load_valid && !in_serve;
      xfer     = in_serve && idx_ready;
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      remaining_d = remaining_q;
      empty_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_acc) begin
               pending_d   = load_vec;
               remaining_d = popcount32(load_vec);
               if (load_vec == 32'd0) begin
                  empty_d = 1'b1;
               end else begin
                  state_d = SERVE;
               end
            end
         end
         SERVE: begin
            if (xfer) begin
               pending_d = pending_q & ~sel_onehot;
               // remaining is at least 1 in SERVE, so this cannot wrap.
               if (remaining_q != 6'd0) begin
                  remaining_d = remaining_q - 6'd1;
               end
               if (is_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         remaining_q <= '0;
         empty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         remaining_q <= remaining_d;
         empty_q     <= empty_d;
      end
   end

   always_comb begin
      load_ready  = !in_serve;
      idx_valid   = in_serve;
      idx         = in_serve ? sel_idx : 5'd0;
      idx_last    = is_last;
      remaining   = in_serve ? remaining_q : 6'd0;
      empty_pulse = empty_q;
   end

endmodule

// File: tb/tb_encode32_scan.sv
// Bench for encode32_scan: directed table, hand-written corner sequences and a
// randomized run against an index-queue model, on both service orders at once.
module tb_encode32_scan;

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic [31:0] load_vec;
   logic        idx_ready;

   logic        lrdy_lo, vld_lo, last_lo, empty_lo;
   logic [4:0]  idx_lo;
   logic [5:0]  rem_lo;
   logic        lrdy_hi, vld_hi, last_hi, empty_hi;
   logic [4:0]  idx_hi;
   logic [5:0]  rem_hi;

   int checks = 0;
   int errors = 0;

   int  q_lo[$];
   int  q_hi[$];
   bit  exp_empty;

   encode32_scan #(.LOW_FIRST(1'b1)) dut_lo (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lrdy_lo),
      .load_vec(load_vec), .idx_valid(vld_lo), .idx_ready(idx_ready), .idx(idx_lo),
      .idx_last(last_lo), .empty_pulse(empty_lo), .remaining(rem_lo)
   );

   encode32_scan #(.LOW_FIRST(1'b0)) dut_hi (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lrdy_hi),
      .load_vec(load_vec), .idx_valid(vld_hi), .idx_ready(idx_ready), .idx(idx_hi),
      .idx_last(last_hi), .empty_pulse(empty_hi), .remaining(rem_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        lv;
      logic [31:0] vec;
      logic        rdy;
      logic        vld;
      logic [4:0]  e_idx_lo;
      logic [4:0]  e_idx_hi;
      logic        last;
      logic [5:0]  rem;
      logic        empty;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, " vld_lo"}, 32'(vld_lo), 32'd0);
      chk({nm, " vld_hi"}, 32'(vld_hi), 32'd0);
      chk({nm, " lrdy_lo"}, 32'(lrdy_lo), 32'd1);
      chk({nm, " lrdy_hi"}, 32'(lrdy_hi), 32'd1);
      chk({nm, " idx_lo"}, 32'(idx_lo), 32'd0);
      chk({nm, " idx_hi"}, 32'(idx_hi), 32'd0);
      chk({nm, " last"}, 32'({last_lo, last_hi}), 32'd0);
      chk({nm, " rem"}, 32'({rem_lo, rem_hi}), 32'd0);
      chk({nm, " empty"}, 32'({empty_lo, empty_hi}), 32'd0);
   endtask

   // Model: the indices still to be delivered, in delivery order.
   task automatic model_check(input string nm);
      int n;
      n = q_lo.size();
      chk({nm, " vld_lo"}, 32'(vld_lo), 32'(n != 0));
      chk({nm, " vld_hi"}, 32'(vld_hi), 32'(n != 0));
      chk({nm, " lrdy_lo"}, 32'(lrdy_lo), 32'(n == 0));
      chk({nm, " lrdy_hi"}, 32'(lrdy_hi), 32'(n == 0));
      chk({nm, " idx_lo"}, 32'(idx_lo), (n != 0) ? 32'(q_lo[0]) : 32'd0);
      chk({nm, " idx_hi"}, 32'(idx_hi), (n != 0) ? 32'(q_hi[0]) : 32'd0);
      chk({nm, " last_lo"}, 32'(last_lo), 32'(n == 1));
      chk({nm, " last_hi"}, 32'(last_hi), 32'(n == 1));
      chk({nm, " rem_lo"}, 32'(rem_lo), 32'(n));
      chk({nm, " rem_hi"}, 32'(rem_hi), 32'(n));
      chk({nm, " empty_lo"}, 32'(empty_lo), 32'(exp_empty));
      chk({nm, " empty_hi"}, 32'(empty_hi), 32'(exp_empty));
   endtask

   task automatic model_step(input logic lv, input logic [31:0] vec, input logic rdy);
      if (q_lo.size() == 0) begin
         exp_empty = lv && (vec == 32'd0);
         if (lv) begin
            for (int i = 0; i < 32; i++) if (vec[i]) q_lo.push_back(i);
            for (int i = 31; i >= 0; i--) if (vec[i]) q_hi.push_back(i);
         end
      end else begin
         exp_empty = 1'b0;
         if (rdy) begin
            void'(q_lo.pop_front());
            void'(q_hi.pop_front());
         end
      end
   endtask

   task automatic model_reset();
      q_lo.delete();
      q_hi.delete();
      exp_empty = 1'b0;
   endtask

   // Called just after a falling edge: apply inputs for the next rising edge.
   task automatic drive(input logic lv, input logic [31:0] vec, input logic rdy);
      load_valid = lv;
      load_vec   = vec;
      idx_ready  = rdy;
      model_step(lv, vec, rdy);
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_vec   = 32'd0;
      idx_ready  = 1'b0;
      model_reset();

      //                lv    vec            rdy   vld   lo     hi     last  rem   empty
      tbl[0]  = '{1'b1, 32'h8000_0011, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 6'd0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd0,  5'd31, 1'b0, 6'd3, 1'b0};
      tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd4,  5'd4,  1'b0, 6'd2, 1'b0};
      tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd31, 5'd0,  1'b1, 6'd1, 1'b0};
      tbl[4]  = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 6'd0, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 6'd0, 1'b1};
      tbl[6]  = '{1'b1, 32'h4,         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 6'd0, 1'b0};
      tbl[7]  = '{1'b1, 32'h2,         1'b0, 1'b1, 5'd2,  5'd2,  1'b1, 6'd1, 1'b0};
      tbl[8]  = '{1'b1, 32'h2,         1'b1, 1'b1, 5'd2,  5'd2,  1'b1, 6'd1, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 6'd0, 1'b0};
      tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 6'd0, 1'b0};

      // Reset state, held across a rising edge
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      #1;

      // Directed table
      for (int k = 0; k < 11; k++) begin
         chk($sformatf("tbl%0d vld_lo", k), 32'(vld_lo), 32'(tbl[k].vld));
         chk($sformatf("tbl%0d vld_hi", k), 32'(vld_hi), 32'(tbl[k].vld));
         chk($sformatf("tbl%0d lrdy", k), 32'({lrdy_lo, lrdy_hi}), tbl[k].vld ? 32'd0 : 32'd3);
         chk($sformatf("tbl%0d idx_lo", k), 32'(idx_lo), 32'(tbl[k].e_idx_lo));
         chk($sformatf("tbl%0d idx_hi", k), 32'(idx_hi), 32'(tbl[k].e_idx_hi));
         chk($sformatf("tbl%0d last", k), 32'({last_lo, last_hi}), tbl[k].last ? 32'd3 : 32'd0);
         chk($sformatf("tbl%0d rem_lo", k), 32'(rem_lo), 32'(tbl[k].rem));
         chk($sformatf("tbl%0d rem_hi", k), 32'(rem_hi), 32'(tbl[k].rem));
         chk($sformatf("tbl%0d empty", k), 32'({empty_lo, empty_hi}), tbl[k].empty ? 32'd3 : 32'd0);
         drive(tbl[k].lv, tbl[k].vec, tbl[k].rdy);
      end

      // All-ones vector drained with idx_ready toggling
      drive(1'b1, 32'hFFFF_FFFF, 1'b0);
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("full%0d idx_lo", k), 32'(idx_lo), 32'(k));
         chk($sformatf("full%0d idx_hi", k), 32'(idx_hi), 32'(31 - k));
         chk($sformatf("full%0d rem", k), 32'(rem_lo), 32'(32 - k));
         drive(1'b0, 32'd0, 1'b0);
         chk($sformatf("full%0d hold_lo", k), 32'(idx_lo), 32'(k));
         chk($sformatf("full%0d hold_rem", k), 32'(rem_lo), 32'(32 - k));
         chk($sformatf("full%0d last", k), 32'(last_lo), 32'(k == 31));
         drive(1'b0, 32'd0, 1'b1);
      end
      chk_idle("full done");

      // Asynchronous reset mid-drain
      drive(1'b1, 32'h0000_00F0, 1'b1);
      drive(1'b0, 32'd0, 1'b1);
      drive(1'b0, 32'd0, 1'b1);
      chk("mid idx_lo", 32'(idx_lo), 32'd6);
      chk("mid idx_hi", 32'(idx_hi), 32'd5);
      chk("mid rem", 32'(rem_lo), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("async rst");
      model_reset();
      load_valid = 1'b0;
      @(negedge clk);
      chk_idle("rst held");
      rst_n = 1'b1;
      drive(1'b1, 32'h1, 1'b0);
      chk("post idx_lo", 32'(idx_lo), 32'd0);
      chk("post idx_hi", 32'(idx_hi), 32'd0);
      chk("post last", 32'({last_lo, last_hi}), 32'd3);
      chk("post vld", 32'({vld_lo, vld_hi}), 32'd3);
      drive(1'b0, 32'd0, 1'b1);
      chk_idle("post done");

      // Randomized traffic against the queue model
      for (int c = 0; c < 600; c++) begin
         logic [31:0] v;
         int sel;
         model_check($sformatf("rnd%0d", c));
         sel = $urandom_range(0, 3);
         case (sel)
            0:       v = 32'd0;
            1:       v = 32'd1 << $urandom_range(0, 31);
            2:       v = $urandom & $urandom & $urandom;
            default: v = $urandom;
         endcase
         drive(1'(($urandom_range(0, 2)) != 0), v, 1'(($urandom_range(0, 3)) != 0));
      end
      model_check("rnd end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
